// File: rtl/bru_pipelined_if.sv
// Request/result bundle between the issue stage, the branch unit and its consumer.
// The slave modport is the branch unit's view; the master modport is the view of its environment.
interface bru_pipelined_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  bru_flush_in;
  logic                  bru_cnt_clear_in;
  logic                  bru_valid_in;
  logic                  bru_ready_out;
  logic [3:0]            bru_uop_in;
  logic                  bru_prediction_in;
  logic [DATA_WIDTH-1:0] bru_pc_in;
  logic [DATA_WIDTH-1:0] bru_rs1_in;
  logic [DATA_WIDTH-1:0] bru_rs2_in;
  logic [DATA_WIDTH-1:0] bru_imm_in;
  logic                  bru_valid_out;
  logic                  bru_ready_in;
  logic                  bru_taken_out;
  logic                  bru_correction_out;
  logic                  bru_illegal_out;
  logic [DATA_WIDTH-1:0] bru_target_out;
  logic [DATA_WIDTH-1:0] bru_link_out;
  logic [CNT_WIDTH-1:0]  bru_mispredict_cnt_out;

  modport slave (
    input  bru_flush_in, bru_cnt_clear_in, bru_valid_in, bru_uop_in, bru_prediction_in,
           bru_pc_in, bru_rs1_in, bru_rs2_in, bru_imm_in, bru_ready_in,
    output bru_ready_out, bru_valid_out, bru_taken_out, bru_correction_out,
           bru_illegal_out, bru_target_out, bru_link_out, bru_mispredict_cnt_out
  );

  modport master (
    output bru_flush_in, bru_cnt_clear_in, bru_valid_in, bru_uop_in, bru_prediction_in,
           bru_pc_in, bru_rs1_in, bru_rs2_in, bru_imm_in, bru_ready_in,
    input  bru_ready_out, bru_valid_out, bru_taken_out, bru_correction_out,
           bru_illegal_out, bru_target_out, bru_link_out, bru_mispredict_cnt_out
  );
endinterface

// File: rtl/bru_pipelined.sv
// Branch resolution unit: resolves direction/target in one registered stage with a
// valid/ready output handshake and a saturating misprediction counter.
module bru_pipelined #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_INC     = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                clock_in,
  input  logic                reset_in,
  bru_pipelined_if.slave      bus
);

  localparam logic [3:0] UOP_BEQ  = 4'b0000;
  localparam logic [3:0] UOP_BNE  = 4'b0001;
  localparam logic [3:0] UOP_BLT  = 4'b0100;
  localparam logic [3:0] UOP_BGE  = 4'b0101;
  localparam logic [3:0] UOP_BLTU = 4'b0110;
  localparam logic [3:0] UOP_BGEU = 4'b0111;
  localparam logic [3:0] UOP_JAL  = 4'b1000;
  localparam logic [3:0] UOP_JALR = 4'b1001;

  logic                  valid_q, taken_q, corr_q, ill_q;
  logic [DATA_WIDTH-1:0] target_q, link_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  logic                  taken_d, corr_d, ill_d;
  logic [DATA_WIDTH-1:0] target_d, link_d, pc_rel, rs1_rel;
  logic                  accept, transfer;

  assign bus.bru_ready_out = !valid_q || bus.bru_ready_in;
  assign accept            = bus.bru_valid_in && bus.bru_ready_out;
  assign transfer          = valid_q && bus.bru_ready_in;

  assign pc_rel  = bus.bru_pc_in + bus.bru_imm_in;
  assign rs1_rel = bus.bru_rs1_in + bus.bru_imm_in;
  assign link_d  = bus.bru_pc_in + DATA_WIDTH'(PC_INC);

  always_comb begin
    taken_d  = 1'b0;
    ill_d    = 1'b0;
    target_d = pc_rel;
    case (bus.bru_uop_in)
      UOP_BEQ:  taken_d = (bus.bru_rs1_in == bus.bru_rs2_in);
      UOP_BNE:  taken_d = (bus.bru_rs1_in != bus.bru_rs2_in);
      UOP_BLT:  taken_d = ($signed(bus.bru_rs1_in) <  $signed(bus.bru_rs2_in));
      UOP_BGE:  taken_d = ($signed(bus.bru_rs1_in) >= $signed(bus.bru_rs2_in));
      UOP_BLTU: taken_d = (bus.bru_rs1_in <  bus.bru_rs2_in);
      UOP_BGEU: taken_d = (bus.bru_rs1_in >= bus.bru_rs2_in);
      UOP_JAL:  taken_d = 1'b1;
      UOP_JALR: begin
        taken_d  = 1'b1;
        target_d = {rs1_rel[DATA_WIDTH-1:1], 1'b0};
      end
      default:  ill_d = 1'b1;
    endcase
    if (!taken_d) target_d = link_d;
    corr_d = (bus.bru_prediction_in != taken_d);
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      valid_q  <= 1'b0;
      taken_q  <= 1'b0;
      corr_q   <= 1'b0;
      ill_q    <= 1'b0;
      target_q <= '0;
      link_q   <= '0;
    end else if (bus.bru_flush_in) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q  <= 1'b1;
      taken_q  <= taken_d;
      corr_q   <= corr_d;
      ill_q    <= ill_d;
      target_q <= target_d;
      link_q   <= link_d;
    end else if (transfer) begin
      valid_q <= 1'b0;
    end
  end

  // A flushed result is treated as discarded even if the consumer was ready.
  always_ff @(posedge clock_in) begin
    if (reset_in || bus.bru_cnt_clear_in)
      cnt_q <= '0;
    else if (transfer && corr_q && !bus.bru_flush_in && (cnt_q != {CNT_WIDTH{1'b1}}))
      cnt_q <= cnt_q + 1'b1;
  end

  assign bus.bru_valid_out          = valid_q;
  assign bus.bru_taken_out          = taken_q;
  assign bus.bru_correction_out     = corr_q;
  assign bus.bru_illegal_out        = ill_q;
  assign bus.bru_target_out         = target_q;
  assign bus.bru_link_out           = link_q;
  assign bus.bru_mispredict_cnt_out = cnt_q;

endmodule

// File: tb/tb_bru_pipelined.sv
// Directed bench for bru_pipelined with a 2-bit counter so saturation is reachable quickly.
module tb_bru_pipelined;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  bru_pipelined_if #(.DATA_WIDTH(32), .CNT_WIDTH(2)) bus ();

  bru_pipelined #(.DATA_WIDTH(32), .PC_INC(4), .CNT_WIDTH(2)) dut (
    .clock_in (clk),
    .reset_in (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [3:0] uop, input logic pred, input logic [31:0] pc,
                     input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
    bus.bru_valid_in      = 1'b1;
    bus.bru_uop_in        = uop;
    bus.bru_prediction_in = pred;
    bus.bru_pc_in         = pc;
    bus.bru_rs1_in        = rs1;
    bus.bru_rs2_in        = rs2;
    bus.bru_imm_in        = imm;
  endtask

  task automatic res(input string tag, input logic v, input logic t, input logic c,
                     input logic il, input logic [31:0] tgt, input logic [31:0] lnk);
    chk({tag, ".valid"},  bus.bru_valid_out,      v);
    chk({tag, ".taken"},  bus.bru_taken_out,      t);
    chk({tag, ".corr"},   bus.bru_correction_out, c);
    chk({tag, ".ill"},    bus.bru_illegal_out,    il);
    chk({tag, ".target"}, bus.bru_target_out,     tgt);
    chk({tag, ".link"},   bus.bru_link_out,       lnk);
  endtask

  initial begin
    rst = 1'b1;
    bus.bru_flush_in = 1'b0;
    bus.bru_cnt_clear_in = 1'b0;
    bus.bru_ready_in = 1'b1;
    // request presented during reset must be dropped
    req(4'b1000, 1'b0, 32'h40, 32'h0, 32'h0, 32'h8);
    tick();
    tick();
    res("reset", 0, 0, 0, 0, 32'h0, 32'h0);
    chk("reset.cnt", bus.bru_mispredict_cnt_out, 0);
    rst = 1'b0;
    bus.bru_valid_in = 1'b0;
    #1;
    chk("reset.ready", bus.bru_ready_out, 1);

    // BEQ taken, predicted not-taken
    req(4'b0000, 1'b0, 32'h100, 32'd5, 32'd5, 32'h20);
    tick();
    res("beq", 1, 1, 1, 0, 32'h120, 32'h104);
    chk("beq.cnt_before", bus.bru_mispredict_cnt_out, 0);
    bus.bru_valid_in = 1'b0;
    tick();
    chk("beq.valid_after", bus.bru_valid_out, 0);
    chk("beq.cnt_after", bus.bru_mispredict_cnt_out, 1);

    // BLT then BLTU back-to-back
    req(4'b0100, 1'b1, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40);
    tick();
    res("blt", 1, 1, 0, 0, 32'h240, 32'h204);
    req(4'b0110, 1'b1, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40);
    tick();
    res("bltu", 1, 0, 1, 0, 32'h204, 32'h204);
    chk("bltu.cnt", bus.bru_mispredict_cnt_out, 1);
    bus.bru_valid_in = 1'b0;
    tick();
    chk("bltu.cnt_after", bus.bru_mispredict_cnt_out, 2);

    // JALR clears bit 0 of the target
    req(4'b1001, 1'b1, 32'h300, 32'h203, 32'h0, 32'h10);
    tick();
    res("jalr", 1, 1, 0, 0, 32'h212, 32'h304);
    bus.bru_valid_in = 1'b0;
    tick();
    chk("jalr.cnt", bus.bru_mispredict_cnt_out, 2);

    // illegal uop held for 3 cycles with a second request waiting
    bus.bru_ready_in = 1'b0;
    req(4'b0010, 1'b1, 32'h400, 32'h0, 32'h0, 32'h0);
    tick();
    res("ill", 1, 0, 1, 1, 32'h404, 32'h404);
    req(4'b0101, 1'b0, 32'h500, 32'd3, 32'd3, 32'h8);
    for (int i = 0; i < 3; i++) begin
      chk("hold.ready", bus.bru_ready_out, 0);
      tick();
      res("hold", 1, 0, 1, 1, 32'h404, 32'h404);
      chk("hold.cnt", bus.bru_mispredict_cnt_out, 2);
    end
    bus.bru_ready_in = 1'b1;
    #1;
    chk("release.ready", bus.bru_ready_out, 1);
    tick();
    res("bge", 1, 1, 1, 0, 32'h508, 32'h504);
    chk("bge.cnt", bus.bru_mispredict_cnt_out, 3);
    bus.bru_valid_in = 1'b0;
    tick();
    chk("sat.valid", bus.bru_valid_out, 0);
    chk("sat.cnt", bus.bru_mispredict_cnt_out, 3);

    // clear wins over a mispredicted transfer in the same cycle
    req(4'b1000, 1'b0, 32'h600, 32'h0, 32'h0, 32'hFFFF_FFF0);
    tick();
    res("jal", 1, 1, 1, 0, 32'h5F0, 32'h604);
    bus.bru_valid_in = 1'b0;
    bus.bru_cnt_clear_in = 1'b1;
    tick();
    bus.bru_cnt_clear_in = 1'b0;
    chk("clear.cnt", bus.bru_mispredict_cnt_out, 0);
    chk("clear.valid", bus.bru_valid_out, 0);

    // BNE mispredict counted, then flush with accept and flush of a held result
    req(4'b0001, 1'b0, 32'h700, 32'd1, 32'd2, 32'h4);
    tick();
    res("bne", 1, 1, 1, 0, 32'h704, 32'h704);
    bus.bru_valid_in = 1'b0;
    tick();
    chk("bne.cnt", bus.bru_mispredict_cnt_out, 1);
    req(4'b0001, 1'b0, 32'h700, 32'd1, 32'd2, 32'h4);
    bus.bru_flush_in = 1'b1;
    tick();
    bus.bru_flush_in = 1'b0;
    chk("flush_acc.valid", bus.bru_valid_out, 0);
    chk("flush_acc.cnt", bus.bru_mispredict_cnt_out, 1);
    bus.bru_ready_in = 1'b0;
    tick();
    chk("flush_hold.valid_pre", bus.bru_valid_out, 1);
    bus.bru_valid_in = 1'b0;
    bus.bru_flush_in = 1'b1;
    tick();
    bus.bru_flush_in = 1'b0;
    bus.bru_ready_in = 1'b1;
    chk("flush_hold.valid", bus.bru_valid_out, 0);
    tick();
    chk("flush_hold.cnt", bus.bru_mispredict_cnt_out, 1);

    // reset while a result is held
    bus.bru_ready_in = 1'b0;
    req(4'b0111, 1'b1, 32'h800, 32'd1, 32'd2, 32'h4);
    tick();
    res("bgeu", 1, 0, 1, 0, 32'h804, 32'h804);
    bus.bru_valid_in = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    res("midrst", 0, 0, 0, 0, 32'h0, 32'h0);
    chk("midrst.cnt", bus.bru_mispredict_cnt_out, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bru_pipelined.md
BRU_PIPELINED -- requirements
Module: bru_pipelined

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of PC, operands, immediate and target.
REQ-002 SHALL have parameter PC_INC, default 4: sequential PC increment (fall-through and link value).
REQ-003 SHALL have parameter CNT_WIDTH, default 16: misprediction counter width.
REQ-004 SHALL use one clock and a synchronous, active-high reset; all state SHALL update on the clock's rising edge.
REQ-005 SHALL have the following ports, one per line: name  direction  width  meaning.
  clock_in  input  1  system clock
  reset_in  input  1  synchronous active-high reset
  bru_flush_in  input  1  discard held result
  bru_cnt_clear_in  input  1  clear misprediction counter
  bru_valid_in  input  1  request valid
  bru_ready_out  output  1  request accepted when high with bru_valid_in
  bru_uop_in  input  4  branch uOP
  bru_prediction_in  input  1  front-end prediction (1 = taken)
  bru_pc_in  input  DATA_WIDTH  branch PC
  bru_rs1_in  input  DATA_WIDTH  R[rs1]
  bru_rs2_in  input  DATA_WIDTH  R[rs2]
  bru_imm_in  input  DATA_WIDTH  sign-extended immediate
  bru_valid_out  output  1  result valid
  bru_ready_in  input  1  consumer ready
  bru_taken_out  output  1  resolved direction
  bru_correction_out  output  1  prediction wrong
  bru_illegal_out  output  1  unsupported uOP
  bru_target_out  output  DATA_WIDTH  next PC
  bru_link_out  output  DATA_WIDTH  pc + PC_INC
  bru_mispredict_cnt_out  output  CNT_WIDTH  saturating misprediction count

Function
REQ-006 SHALL decode uOPs: 0000 BEQ, 0001 BNE, 0100 BLT (signed), 0101 BGE (signed), 0110 BLTU, 0111 BGEU, 1000 JAL (always taken), 1001 JALR (always taken).
REQ-007 SHALL treat any other uOP as illegal: taken=0, illegal=1, correction = prediction.
REQ-008 SHALL compute the taken target as pc+imm for branches/JAL and (rs1+imm) with bit 0 cleared for JALR, all modulo 2^DATA_WIDTH.
REQ-009 SHALL drive the target as the taken target when taken=1, else pc+PC_INC.
REQ-010 SHALL set correction = (prediction != taken).
REQ-011 SHALL register all results in a single output stage; latency from accepted request to bru_valid_out is 1 cycle.
REQ-012 SHALL drive bru_ready_out = !bru_valid_out || bru_ready_in (combinational, no bubble at full throughput).
REQ-013 SHALL accept a request when bru_valid_in && bru_ready_out, loading the output stage and setting bru_valid_out.
REQ-014 SHALL clear bru_valid_out after a transfer (bru_valid_out && bru_ready_in) with no new accept in the same cycle.
REQ-015 SHALL hold all outputs stable while bru_valid_out=1 and bru_ready_in=0.
REQ-016 SHALL, on bru_flush_in=1, clear bru_valid_out next cycle and discard any request accepted in that cycle; flush has priority over accept.
REQ-017 SHALL increment the counter by 1 on each transfer with bru_correction_out=1, saturating at all-ones (no wrap).
REQ-018 SHALL give bru_cnt_clear_in priority over increment; the counter SHALL be 0 the cycle after clear.
REQ-019 SHALL not count a held result more than once, nor a result discarded by flush.

Reset
REQ-020 SHALL, with reset_in=1 at a clock edge, set bru_valid_out, taken, correction and illegal to 0, target and link to 0, and the counter to 0.
REQ-021 SHALL give reset priority over flush, clear and accept; a request presented during reset SHALL be dropped.

Verification
REQ-022 BEQ, rs1=rs2=5, pc=0x100, imm=0x20, pred=0 -> next cycle valid=1, taken=1, target=0x120, link=0x104, correction=1, counter 0->1 on transfer.
REQ-023 BLT vs BLTU with rs1=0xFFFFFFFF, rs2=1 -> BLT taken=1; BLTU taken=0, target=pc+4.
REQ-024 JALR, rs1=0x203, imm=0x10, pred=1 -> target=0x212, taken=1, correction=0.
REQ-025 Back-to-back requests with bru_ready_in held 0 for 3 cycles -> first result held stable, bru_ready_out=0, second accepted in the cycle ready returns, counted once each.
REQ-026 Counter at all-ones plus a mispredicted transfer -> stays all-ones; clear and mispredicted transfer in same cycle -> 0.
REQ-027 Flush in the same cycle as an accept, and reset mid-hold -> bru_valid_out=0 next cycle, counter unchanged by flush, 0 after reset.
